sonar_tof_timer: RTL
====================

// Module: sonar_tof_timer
// PURPOSE
//  Downstream stage of the sonar core. Consumes the core's cmp output and measures echo time-of-flight.
//  Time is counted in ce_pcm ticks from a software start pulse to the first qualified cmp assertion.
//  Raw cmp has no timing meaning on its own; this block turns it into a readable TOF value plus done/timeout status and an IRQ.
// PARAMETERS
//  CNT_W   16  width of the tick counter, tof_o, blank_len_i and max_len_i
//  DEB_LEN 4   consecutive high cmp samples required (only with SONAR_TOF_DEBOUNCE_EN)
// PORTS
//  wb_clk_i     in   1      system clock; the only clock
//  wb_rst_i     in   1      asynchronous reset, active-high
//  mclear       in   1      synchronous master clear, active-high
//  ce_pcm       in   1      PCM pace clock-enable; one tick = one TOF unit
//  cmp          in   1      comparator output of the sonar core
//  start_i      in   1      one-cycle pulse; starts a measurement
//  blank_len_i  in   CNT_W  ticks after start during which cmp is ignored
//  max_len_i    in   CNT_W  timeout tick count; 0 = timeout at 2^CNT_W-1
//  tof_o        out  CNT_W  captured tick count; all-ones on timeout
//  done_o       out  1      level; measurement finished (hit or timeout)
//  timeout_o    out  1      level; last measurement ended with no echo
//  busy_o       out  1      high in BLANK or LISTEN
//  irq_o        out  1      one-cycle pulse on entry to DONE
// BEHAVIOUR
//  Reset (wb_rst_i) or mclear:
//   - state=IDLE, cnt=0.
//   - tof_o=0, done_o=0, timeout_o=0, busy_o=0, irq_o=0.
//   - mclear beats start_i when both occur in the same cycle.
//  FSM states: IDLE, BLANK, LISTEN, DONE.
//  start_i in any state:
//   - cnt<=0, done_o<=0, timeout_o<=0.
//   - Next state is BLANK, or LISTEN directly if blank_len_i==0.
//   - A start during BLANK/LISTEN restarts the measurement.
//   - tof_o keeps its last value until the next capture.
//  Counting:
//   - On each ce_pcm cycle in BLANK/LISTEN, cnt<=cnt+1.
//   - So the k-th tick after start carries value k.
//   - Saturates at 2^CNT_W-1; no wrap.
//  BLANK: cmp ignored. The tick where the new cnt equals blank_len_i moves to LISTEN.
//  LISTEN: the first tick with qualified cmp high captures tof_o<=k (the new cnt), then goes to DONE.
//  Timeout, checked in BLANK and LISTEN:
//   - The tick where new cnt equals the limit gives tof_o<=all-ones, timeout_o<=1, then DONE.
//   - Limit is max_len_i, or 2^CNT_W-1 when max_len_i==0.
//  Same-tick hit and timeout in LISTEN: the hit wins.
//  max_len_i <= blank_len_i: timeout fires while still in BLANK.
//  Latency: capture tick in cycle T gives tof_o/done_o/irq_o valid in cycle T+1.
//  DONE: done_o=1, busy_o=0. Holds until start_i or mclear; cmp and ce_pcm are ignored.
//  start_i without ce_pcm: the state changes immediately; counting waits for the next ce_pcm.
//  blank_len_i/max_len_i: sampled every tick; software must hold them stable while busy_o=1.
// CONFIGURATION
//  SONAR_TOF_DEBOUNCE_EN defined:
//   - cmp is qualified only after DEB_LEN consecutive ticks high in LISTEN.
//   - tof_o = tick value of the FIRST tick of that run.
//   - A low sample resets the run.
//   - A run still open at timeout is a timeout.
//  SONAR_TOF_DEBOUNCE_EN undefined: a single high sample on a LISTEN tick qualifies. DEB_LEN is unused.
// STRUCTURE
//  Shared definitions file: FSM state encoding constants (IDLE=0, BLANK=1, LISTEN=2, DONE=3) and the CNT_W default.
//  Sub-module sonar_cmp_qual: cmp sampling on ce_pcm plus the optional debounce run counter.
//   - Outputs hit_o and hit_cnt_o, the start tick of the run.
//   - Cleared when not in LISTEN.
//  The FSM, counter and output registers live in this module.
// TESTING
//  1. blank=10, max=1000, cmp high from tick 50 -> tof_o=50, done_o=1, irq_o 1-cycle pulse at T+1, timeout_o=0.
//  2. cmp high during ticks 1..10 then low, blank=10 -> no capture; max=200 -> tof_o=16'hFFFF, timeout_o=1 at tick 200.
//  3. cmp high first at tick 200 = max -> hit wins: tof_o=200, timeout_o=0.
//  4. start at tick 30 of a running measurement -> cnt restarts; echo 40 ticks later gives tof_o=40. mclear+start same cycle -> IDLE.
//  5. blank=0, max=0, cmp low -> LISTEN directly; timeout at tick 65535; counter never wraps.
//  6. SONAR_TOF_DEBOUNCE_EN, DEB_LEN=4: cmp pattern 1,1,0,1,1,1,1 from tick 20 -> tof_o=23. Undefined: same stimulus -> tof_o=20.

Source files
------------

// File: rtl/sonar_tof_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sonar_tof_timer_pkg
//  Purpose  : Shared definitions for the sonar time-of-flight timer: FSM
//             state encoding and the default tick-counter width.
//  Revision : 1.0 - initial release
// ============================================================================
package sonar_tof_timer_pkg;

    // Default width of the tick counter and of all tick-valued ports
    localparam int c_CNT_W_DEFAULT = 16;

    // Measurement FSM encoding; the numeric values are visible to software
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BLANK  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_DONE   = 2'd3
    } tof_state_t;

endpackage
`default_nettype wire

// File: rtl/sonar_tof_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sonar_tof_timer_if
//  Purpose  : Software-facing control/status bundle of the TOF timer.
//             master = register side (drives start and lengths),
//             slave  = the timer itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface sonar_tof_timer_if
    import sonar_tof_timer_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
);
    logic             start_i;
    logic [CNT_W-1:0] blank_len_i;
    logic [CNT_W-1:0] max_len_i;
    logic [CNT_W-1:0] tof_o;
    logic             done_o;
    logic             timeout_o;
    logic             busy_o;
    logic             irq_o;

    modport master (
        output start_i, blank_len_i, max_len_i,
        input  tof_o, done_o, timeout_o, busy_o, irq_o
    );

    modport slave (
        input  start_i, blank_len_i, max_len_i,
        output tof_o, done_o, timeout_o, busy_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/sonar_cmp_qual.sv
`default_nettype none
// ============================================================================
//  Module   : sonar_cmp_qual
//  Purpose  : Samples the comparator on ce_pcm ticks while listening and
//             reports a qualified echo (hit_o) together with the tick value
//             at which the qualifying run began (hit_cnt_o).
//             Build option SONAR_TOF_DEBOUNCE_EN: an echo needs DEB_LEN
//             consecutive high samples; otherwise one high sample suffices.
//  Revision : 1.0 - initial release
// ============================================================================
module sonar_cmp_qual
    import sonar_tof_timer_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
`ifdef SONAR_TOF_DEBOUNCE_EN
    ,
    parameter int DEB_LEN = 4
`endif
) (
`ifdef SONAR_TOF_DEBOUNCE_EN
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clr,
`endif
    input  wire logic             i_listen,
    input  wire logic             i_tick,
    input  wire logic             i_cmp,
    input  wire logic [CNT_W-1:0] i_tick_cnt,
    output logic                  hit_o,
    output logic [CNT_W-1:0]      hit_cnt_o
);

`ifdef SONAR_TOF_DEBOUNCE_EN
    localparam int c_RUN_W = $clog2(DEB_LEN + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_LAST = c_RUN_W'(DEB_LEN - 1);

    logic [c_RUN_W-1:0] r_run;
    logic [CNT_W-1:0]   r_run_start;
    logic               w_sample_hi;

    assign w_sample_hi = i_listen & i_tick & i_cmp;

    // The sample that completes the run is the qualifying one; the run's
    // first tick is the reported echo time.
    assign hit_o     = w_sample_hi && (r_run == c_RUN_LAST);
    assign hit_cnt_o = (r_run == '0) ? i_tick_cnt : r_run_start;

    // Track the length and start tick of the current run of high samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run       <= '0;
            r_run_start <= '0;
        end else if (i_clr) begin
            r_run       <= '0;
        end else if (i_listen && i_tick) begin
            if (i_cmp) begin
                if (r_run == '0) begin
                    r_run_start <= i_tick_cnt;
                end
                if (r_run != c_RUN_LAST) begin
                    r_run <= r_run + c_RUN_W'(1);
                end
            end else begin
                r_run <= '0;
            end
        end
    end
`else
    // Any high sample on a listening tick is an echo at that tick
    assign hit_o     = i_listen & i_tick & i_cmp;
    assign hit_cnt_o = i_tick_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/sonar_tof_timer.sv
`default_nettype none
// ============================================================================
//  Module   : sonar_tof_timer
//  Purpose  : Echo time-of-flight timer. Counts ce_pcm ticks from a software
//             start pulse to the first qualified comparator assertion after a
//             blanking window, or flags a timeout. Reports TOF, done/timeout
//             status and a one-cycle IRQ on completion.
//             Build option SONAR_TOF_DEBOUNCE_EN enables comparator debounce
//             (DEB_LEN consecutive high samples).
//  Revision : 1.0 - initial release
// ============================================================================
module sonar_tof_timer
    import sonar_tof_timer_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
`ifdef SONAR_TOF_DEBOUNCE_EN
    ,
    parameter int DEB_LEN = 4
`endif
) (
    input  wire logic        wb_clk_i,
    input  wire logic        wb_rst_i,
    input  wire logic        mclear,
    input  wire logic        ce_pcm,
    input  wire logic        cmp,
    sonar_tof_timer_if.slave bus
);

    localparam logic [CNT_W-1:0] c_ALL_ONES = '1;

    tof_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_tof;
    logic             r_done;
    logic             r_timeout;
    logic             r_busy;
    logic             r_irq;

    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_limit;
    logic             w_listen;
    logic             w_hit;
    logic [CNT_W-1:0] w_hit_cnt;

    // Tick value this tick would carry; the counter saturates instead of wrapping
    assign w_cnt_next = (r_cnt == c_ALL_ONES) ? r_cnt : r_cnt + CNT_W'(1);
    // A zero max length means "as long as the counter can go"
    assign w_limit    = (bus.max_len_i == '0) ? c_ALL_ONES : bus.max_len_i;
    assign w_listen   = (r_state == ST_LISTEN);

    sonar_cmp_qual #(
        .CNT_W      (CNT_W)
`ifdef SONAR_TOF_DEBOUNCE_EN
        ,
        .DEB_LEN    (DEB_LEN)
`endif
    ) u_cmp_qual (
`ifdef SONAR_TOF_DEBOUNCE_EN
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .i_clr      (mclear | bus.start_i | ~w_listen),
`endif
        .i_listen   (w_listen),
        .i_tick     (ce_pcm),
        .i_cmp      (cmp),
        .i_tick_cnt (w_cnt_next),
        .hit_o      (w_hit),
        .hit_cnt_o  (w_hit_cnt)
    );

    // Measurement FSM with tick counter and registered status outputs
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tof     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_irq     <= 1'b0;
        end else if (mclear) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_tof     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_irq     <= 1'b0;
        end else if (bus.start_i) begin
            // (Re)start; a coincident tick is not counted
            r_state   <= (bus.blank_len_i == '0) ? ST_LISTEN : ST_BLANK;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b1;
            r_irq     <= 1'b0;
        end else begin
            r_irq <= 1'b0;
            case (r_state)
                ST_BLANK: begin
                    if (ce_pcm) begin
                        r_cnt <= w_cnt_next;
                        // Timeout takes priority so a limit inside the
                        // blanking window still terminates the measurement
                        if (w_cnt_next == w_limit) begin
                            r_state   <= ST_DONE;
                            r_tof     <= c_ALL_ONES;
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_irq     <= 1'b1;
                        end else if (w_cnt_next == bus.blank_len_i) begin
                            r_state <= ST_LISTEN;
                        end
                    end
                end
                ST_LISTEN: begin
                    if (ce_pcm) begin
                        r_cnt <= w_cnt_next;
                        // An echo on the limit tick still counts as an echo
                        if (w_hit) begin
                            r_state <= ST_DONE;
                            r_tof   <= w_hit_cnt;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_irq   <= 1'b1;
                        end else if (w_cnt_next == w_limit) begin
                            r_state   <= ST_DONE;
                            r_tof     <= c_ALL_ONES;
                            r_timeout <= 1'b1;
                            r_done    <= 1'b1;
                            r_busy    <= 1'b0;
                            r_irq     <= 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE wait for start or master clear
                end
            endcase
        end
    end

    assign bus.tof_o     = r_tof;
    assign bus.done_o    = r_done;
    assign bus.timeout_o = r_timeout;
    assign bus.busy_o    = r_busy;
    assign bus.irq_o     = r_irq;

endmodule
`default_nettype wire
